// File: rtl/game_over_monitor_if.sv
// Piece-controller / game-FSM side bundle of the top-out monitor: lock and spawn strobes in, status out.
// The mask is declared [0:N*N-1], so a literal's MSB is mask bit 0 (matrix row 0, column 0).
interface game_over_monitor_if #(
  parameter int PIECE_N = 4,
  parameter int Y_W     = 5
);
  logic                         new_game;
  logic                         lock_stb;
  logic [Y_W-1:0]               pos_y;
  logic [0:PIECE_N*PIECE_N-1]   float;
  logic                         spawn_stb;
  logic                         spawn_collide;
  logic                         busy;
  logic                         check_done;
  logic                         game_over;
  logic [1:0]                   over_cause;

  modport master (
    output new_game, lock_stb, pos_y, float, spawn_stb, spawn_collide,
    input  busy, check_done, game_over, over_cause
  );

  modport slave (
    input  new_game, lock_stb, pos_y, float, spawn_stb, spawn_collide,
    output busy, check_done, game_over, over_cause
  );
endinterface

// File: rtl/game_over_monitor.sv
// Sequential top-out detector: scans a locked piece one matrix row per cycle for lock-out,
// flags block-out on a colliding spawn, and holds a sticky game-over status until new_game.
module game_over_monitor #(
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int Y_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  game_over_monitor_if.slave   bus,
  output logic [1:0]           state_dbg
);

  // Handshake: every strobe is a one-cycle pulse sampled at the rising edge. There is no
  // back-pressure; lock_stb arriving while busy=1 or in OVER is simply dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int ROW_W = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(PIECE_N - 1);
  // y = pos_y + r - (N-1) >= BOARD_H  <=>  pos_y + r >= BOARD_H + N - 1, which also rules out y < 0.
  localparam logic [Y_W:0]     HIT_MIN     = (Y_W + 1)'(BOARD_H + PIECE_N - 1);
  localparam logic [1:0]       CAUSE_NONE  = 2'b00;
  localparam logic [1:0]       CAUSE_LOCK  = 2'b01;
  localparam logic [1:0]       CAUSE_BLOCK = 2'b10;

  state_t                       state_q, state_d;
  logic [Y_W-1:0]               pos_q, pos_d;
  logic [0:PIECE_N*PIECE_N-1]   mask_q, mask_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic                         hit_q, hit_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         over_q, over_d;
  logic [1:0]                   cause_q, cause_d;

  logic [PIECE_N-1:0]           rows [PIECE_N];
  logic [Y_W:0]                 y_ext;
  logic                         row_hit;
  logic                         block_out;

  for (genvar g = 0; g < PIECE_N; g++) begin : g_rows
    assign rows[g] = mask_q[g*PIECE_N +: PIECE_N];
  end

  assign y_ext     = {1'b0, pos_q} + (Y_W + 1)'(row_q);
  assign row_hit   = (|rows[row_q]) && (y_ext >= HIT_MIN);
  assign block_out = bus.spawn_stb & bus.spawn_collide;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mask_d  = mask_q;
    row_d   = row_q;
    hit_d   = hit_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    over_d  = over_q;
    cause_d = cause_q;

    if (bus.new_game) begin
      state_d = IDLE;
      row_d   = '0;
      hit_d   = 1'b0;
      over_d  = 1'b0;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (block_out) begin
            state_d = OVER;
            over_d  = 1'b1;
            cause_d = CAUSE_BLOCK;
          end else if (bus.lock_stb) begin
            state_d = SCAN;
            pos_d   = bus.pos_y;
            mask_d  = bus.float;
            row_d   = '0;
            hit_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        SCAN: begin
          if (block_out) begin
            state_d = OVER;
            hit_d   = 1'b0;
            over_d  = 1'b1;
            cause_d = CAUSE_BLOCK;
          end else begin
            hit_d  = hit_q | row_hit;
            busy_d = 1'b1;
            if (row_q == LAST_ROW) begin
              // Outputs are registered, so the verdict is loaded on the edge entering DONE.
              state_d = DONE;
              done_d  = 1'b1;
              if (hit_q | row_hit) begin
                over_d  = 1'b1;
                cause_d = CAUSE_LOCK;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (block_out) begin
            state_d = OVER;
            hit_d   = 1'b0;
            over_d  = 1'b1;
            cause_d = CAUSE_BLOCK;
          end else if (hit_q) begin
            state_d = OVER;
          end else begin
            state_d = IDLE;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      over_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      over_q  <= over_d;
      cause_q <= cause_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.check_done = done_q;
  assign bus.game_over  = over_q;
  assign bus.over_cause = cause_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_game_over_monitor.sv
// Self-checking bench for game_over_monitor (BOARD_H=20, PIECE_N=4): scenario tasks with an
// expected-result queue of {game_over, over_cause} pushed at lock time and popped on check_done.
module tb_game_over_monitor;
  localparam int BOARD_H = 20;
  localparam int PIECE_N = 4;
  localparam int Y_W     = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  game_over_monitor_if #(.PIECE_N(PIECE_N), .Y_W(Y_W)) bus ();

  game_over_monitor #(.BOARD_H(BOARD_H), .PIECE_N(PIECE_N), .Y_W(Y_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.new_game      = 1'b0;
    bus.lock_stb      = 1'b0;
    bus.pos_y         = '0;
    bus.float         = '0;
    bus.spawn_stb     = 1'b0;
    bus.spawn_collide = 1'b0;
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    checks++;
    if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg} !== 7'b0) begin
      errors++;
      $display("FAIL new_game_clear: got busy=%b done=%b go=%b cause=%b st=%0d want all 0",
               bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg);
    end
  endtask

  // Lock a piece in the current (idle) cycle T and follow it through T+6.
  task automatic do_lock(input logic [Y_W-1:0] py, input logic [15:0] m, input logic exp_hit,
                         input string name);
    logic [2:0] got;
    logic [2:0] exp;
    exp_q.push_back(exp_hit ? 3'b101 : 3'b000);
    bus.pos_y    = py;
    bus.float    = m;
    bus.lock_stb = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.lock_stb = 1'b0;
      checks++;
      if (bus.busy !== (k <= 5)) begin
        errors++;
        $display("FAIL %s busy@T+%0d: got %b want %b", name, k, bus.busy, (k <= 5));
      end
      if (bus.check_done === 1'b1) begin
        checks++;
        if (k != 5 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s check_done@T+%0d: got 1 want pulse only at T+5", name, k);
        end else begin
          exp = exp_q.pop_front();
          got = {bus.game_over, bus.over_cause};
          if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got go/cause=%b want %b", name, got, exp);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s no_check_done: got none want 1 pulse", name);
      exp_q.delete();
    end
    checks++;
    if (bus.game_over !== exp_hit) begin
      errors++;
      $display("FAIL %s hold@T+6: got go=%b want %b", name, bus.game_over, exp_hit);
    end
  endtask

  // scenarios
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b go=%b cause=%b st=%0d want all 0",
               bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_no_lockout();
    do_lock(5'd19, 16'h000F, 1'b0, "row3_y19");
    do_lock(5'd21, 16'h0F00, 1'b0, "row1_y19");
    do_lock(5'd1,  16'hFFFF, 1'b0, "negative_rows");
    do_lock(5'd31, 16'h0000, 1'b0, "empty_mask");
  endtask

  task automatic test_lockout();
    do_lock(5'd20, 16'h000F, 1'b1, "row3_y20");
    for (int k = 0; k < 4; k++) begin
      bus.lock_stb = (k == 1);
      bus.pos_y    = 5'd19;
      bus.float    = 16'h000F;
      step();
      checks++;
      if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause} !== 5'b00101) begin
        errors++;
        $display("FAIL lockout_hold k=%0d: got busy=%b done=%b go=%b cause=%b want 0 0 1 01",
                 k, bus.busy, bus.check_done, bus.game_over, bus.over_cause);
      end
    end
    bus.lock_stb = 1'b0;
    pulse_new_game();
    do_lock(5'd22, 16'h0F00, 1'b1, "row1_y20");
    pulse_new_game();
    do_lock(5'd23, 16'hF000, 1'b1, "row0_y20");
    pulse_new_game();
    do_lock(5'd24, 16'h8001, 1'b1, "row0_y21_single");
    pulse_new_game();
  endtask

  task automatic test_back_to_back();
    int exp_cyc[$];
    int c;
    logic [2:0] exp;
    exp_cyc.push_back(5);
    exp_cyc.push_back(11);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    bus.pos_y    = 5'd1;
    bus.float    = 16'hFFFF;
    bus.lock_stb = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      bus.lock_stb = (k == 2 || k == 6);
      if (bus.check_done === 1'b1) begin
        checks++;
        if (exp_cyc.size() == 0 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b extra_check_done@T+%0d: got pulse want none", k);
        end else begin
          c   = exp_cyc.pop_front();
          exp = exp_q.pop_front();
          if (k != c || {bus.game_over, bus.over_cause} !== exp) begin
            errors++;
            $display("FAIL b2b check_done: got T+%0d go/cause=%b want T+%0d %b",
                     k, {bus.game_over, bus.over_cause}, c, exp);
          end
        end
      end
    end
    bus.lock_stb = 1'b0;
    checks++;
    if (exp_cyc.size() != 0) begin
      errors++;
      $display("FAIL b2b missing_check_done: got %0d fewer pulses want 0 missing", exp_cyc.size());
    end
    exp_q.delete();
  endtask

  task automatic test_blockout_scan();
    bus.pos_y    = 5'd20;
    bus.float    = 16'h000F;
    bus.lock_stb = 1'b1;
    step();
    bus.lock_stb = 1'b0;
    step();
    bus.spawn_stb     = 1'b1;
    bus.spawn_collide = 1'b1;
    step();
    bus.spawn_stb     = 1'b0;
    bus.spawn_collide = 1'b0;
    checks++;
    if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg} !== 7'b0011011) begin
      errors++;
      $display("FAIL blockout_scan@T+3: got busy=%b done=%b go=%b cause=%b st=%0d want 0 0 1 10 3",
               bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg);
    end
    for (int k = 4; k <= 10; k++) begin
      bus.lock_stb = (k == 6);
      step();
      checks++;
      if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause} !== 5'b00110) begin
        errors++;
        $display("FAIL blockout_hold@T+%0d: got busy=%b done=%b go=%b cause=%b want 0 0 1 10",
                 k, bus.busy, bus.check_done, bus.game_over, bus.over_cause);
      end
    end
    bus.lock_stb = 1'b0;
    pulse_new_game();
    bus.spawn_stb     = 1'b1;
    bus.spawn_collide = 1'b0;
    step();
    bus.spawn_stb = 1'b0;
    step();
    checks++;
    if ({bus.game_over, bus.over_cause} !== 3'b000) begin
      errors++;
      $display("FAIL spawn_no_collide: got go/cause=%b want 000", {bus.game_over, bus.over_cause});
    end
  endtask

  task automatic test_blockout_in_done();
    bus.pos_y    = 5'd20;
    bus.float    = 16'h000F;
    bus.lock_stb = 1'b1;
    step();
    bus.lock_stb = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    checks++;
    if ({bus.check_done, bus.game_over, bus.over_cause} !== 4'b1101) begin
      errors++;
      $display("FAIL done_lockout@T+5: got done=%b go=%b cause=%b want 1 1 01",
               bus.check_done, bus.game_over, bus.over_cause);
    end
    bus.spawn_stb     = 1'b1;
    bus.spawn_collide = 1'b1;
    step();
    bus.spawn_stb     = 1'b0;
    bus.spawn_collide = 1'b0;
    checks++;
    if ({bus.check_done, bus.game_over, bus.over_cause} !== 4'b0110) begin
      errors++;
      $display("FAIL done_blockout_wins@T+6: got done=%b go=%b cause=%b want 0 1 10",
               bus.check_done, bus.game_over, bus.over_cause);
    end
    pulse_new_game();
  endtask

  task automatic test_reset_mid_scan();
    bus.pos_y    = 5'd20;
    bus.float    = 16'h000F;
    bus.lock_stb = 1'b1;
    step();
    bus.lock_stb = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: got busy=%b done=%b go=%b cause=%b st=%0d want all 0",
               bus.busy, bus.check_done, bus.game_over, bus.over_cause, state_dbg);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({bus.busy, bus.check_done, bus.game_over} !== 3'b000) begin
        errors++;
        $display("FAIL after_reset k=%0d: got busy=%b done=%b go=%b want 0 0 0",
                 k, bus.busy, bus.check_done, bus.game_over);
      end
    end
  endtask

  task automatic test_new_game_priority();
    bus.new_game      = 1'b1;
    bus.spawn_stb     = 1'b1;
    bus.spawn_collide = 1'b1;
    step();
    drive_idle();
    checks++;
    if ({bus.game_over, bus.over_cause, state_dbg} !== 5'b0) begin
      errors++;
      $display("FAIL new_game_vs_spawn: got go=%b cause=%b st=%0d want 0 00 0",
               bus.game_over, bus.over_cause, state_dbg);
    end
    bus.new_game = 1'b1;
    bus.lock_stb = 1'b1;
    bus.pos_y    = 5'd20;
    bus.float    = 16'h000F;
    step();
    drive_idle();
    checks++;
    if ({bus.busy, state_dbg} !== 3'b0) begin
      errors++;
      $display("FAIL new_game_vs_lock: got busy=%b st=%0d want 0 0", bus.busy, state_dbg);
    end
  endtask

  task automatic test_random_locks();
    logic [Y_W-1:0] py;
    logic [15:0]    m;
    logic           hit;
    for (int n = 0; n < 12; n++) begin
      py  = Y_W'($urandom_range(0, 31));
      m   = 16'($urandom_range(0, 65535));
      hit = 1'b0;
      for (int r = 0; r < PIECE_N; r++) begin
        if (m[15 - r*4 -: 4] != 4'h0 && (int'(py) + r - (PIECE_N - 1)) >= BOARD_H) hit = 1'b1;
      end
      do_lock(py, m, hit, "random");
      if (hit) pulse_new_game();
    end
  endtask

  // sequence and final report
  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_no_lockout();
    test_lockout();
    test_back_to_back();
    test_blockout_scan();
    test_blockout_in_done();
    test_reset_mid_scan();
    test_new_game_priority();
    test_random_locks();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
